// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave bus between NUM_MASTERS masters,
// grants whole CYC-framed cycles and aborts stalled transfers with a bus-timeout error.
module wb_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned WB_SEL_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                 m_stb_i,
    input  logic [NUM_MASTERS-1:0]                 m_we_i,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]   m_data_i,
    input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]    m_sel_i,
    output logic [NUM_MASTERS-1:0]                 m_ack_o,
    output logic [NUM_MASTERS-1:0]                 m_err_o,
    output logic [WB_DATA_WIDTH-1:0]               m_data_o,
    output logic                                   s_cyc_o,
    output logic                                   s_stb_o,
    output logic                                   s_we_o,
    output logic [WB_ADDR_WIDTH-1:0]               s_addr_o,
    output logic [WB_DATA_WIDTH-1:0]               s_data_o,
    output logic [WB_SEL_WIDTH-1:0]                s_sel_o,
    input  logic                                   s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0]               s_data_i,
    output logic [NUM_MASTERS-1:0]                 grant_o,
    output logic                                   timeout_o
);

    localparam int unsigned PTR_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned WD_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_ABORT    = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [NUM_MASTERS-1:0]     grant_q, grant_d;
    logic [NUM_MASTERS-1:0]     pick_oh;
    logic [NUM_MASTERS-1:0]     err_q;
    logic                       timeout_q;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [PTR_W-1:0]           owner_idx, next_ptr;
    logic [WD_W-1:0]            wd_q, wd_d;
    logic                       found;
    logic                       in_grant, stall;
    logic                       owner_cyc, owner_stb, owner_we;
    logic [WB_ADDR_WIDTH-1:0]   owner_addr;
    logic [WB_DATA_WIDTH-1:0]   owner_data;
    logic [WB_SEL_WIDTH-1:0]    owner_sel;

    // Owner decode and AND-OR mux of the owner's request onto the slave side
    always_comb begin
        owner_idx  = '0;
        owner_cyc  = 1'b0;
        owner_stb  = 1'b0;
        owner_we   = 1'b0;
        owner_addr = '0;
        owner_data = '0;
        owner_sel  = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (grant_q[i]) begin
                owner_idx  = PTR_W'(i);
                owner_cyc  = m_cyc_i[i];
                owner_stb  = m_stb_i[i];
                owner_we   = m_we_i[i];
                owner_addr = m_addr_i[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
                owner_data = m_data_i[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
                owner_sel  = m_sel_i[i*WB_SEL_WIDTH +: WB_SEL_WIDTH];
            end
        end
        next_ptr = (owner_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner_idx + PTR_W'(1);
    end

    // Round-robin pick: first requester at/after the pointer, else first below it
    always_comb begin
        pick_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (!found && m_cyc_i[i] && (PTR_W'(i) >= ptr_q)) begin
                pick_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (!found && m_cyc_i[i]) begin
                pick_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Slave-side and master-side bus outputs; slave bus only driven while granted
    always_comb begin
        in_grant = (state_q == ST_GRANT);
        s_cyc_o  = in_grant & owner_cyc;
        s_stb_o  = in_grant & owner_cyc & owner_stb;
        s_we_o   = in_grant & owner_cyc & owner_we;
        s_addr_o = in_grant ? owner_addr : '0;
        s_data_o = in_grant ? owner_data : '0;
        s_sel_o  = in_grant ? owner_sel  : '0;
        m_ack_o  = (in_grant && s_ack_i) ? grant_q : '0;
        m_data_o = s_data_i;
        stall    = s_stb_o & ~s_ack_i;
    end

    // Next-state, grant, pointer and watchdog update
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (|m_cyc_i) begin
                    grant_d = pick_oh;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    wd_d    = '0;
                end else if (stall) begin
                    if (wd_q == WD_W'(WD_LIMIT)) begin
                        if (TIMEOUT_CYCLES != 0) begin
                            state_d = ST_ABORT;
                            wd_d    = '0;
                        end
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end else begin
                    wd_d = '0;
                end
            end
            ST_ABORT: begin
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant, pointer, watchdog and abort-pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            wd_q      <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            err_q     <= (state_d == ST_ABORT) ? grant_q : '0;
            timeout_q <= (state_d == ST_ABORT);
        end
    end

    assign grant_o   = grant_q;
    assign m_err_o   = err_q;
    assign timeout_o = timeout_q;

endmodule
